// File: rtl/exec_unit_param.sv
// exec_unit_param: handshaked execute unit with registered result and flags.
// Single-cycle ALU ops complete one edge after accept. Multiply (shift-add) and
// divide (restoring) iterate one bit per cycle, then spend one more edge
// publishing the result, so they complete WIDTH+1 edges after accept.
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-low reset
//   in_valid/in_ready   operation handshake (in_ready high only in IDLE)
//   opcode, op_a, op_b  operation and operands, captured at accept
//   s_r_amount          shift/rotate count
//   flush               synchronous abort of the operation in flight
//   out_valid/out_ready result handshake
//   result              2*WIDTH result (upper half used by mul/div only)
//   zero/carry/ac/parity_flag  registered status flags
//   err                 divide by zero or unsupported opcode
module exec_unit_param #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           opcode,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic [SHAMT_W-1:0]   s_r_amount,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 zero_flag,
    output logic                 carry_flag,
    output logic                 ac_flag,
    output logic                 parity_flag,
    output logic                 err
);

    localparam int unsigned W2    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [4:0] OP_MOV = 5'b00000;
    localparam logic [4:0] OP_ADD = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00010;
    localparam logic [4:0] OP_MUL = 5'b00011;
    localparam logic [4:0] OP_DIV = 5'b00100;
    localparam logic [4:0] OP_INC = 5'b00101;
    localparam logic [4:0] OP_DEC = 5'b00110;
    localparam logic [4:0] OP_AND = 5'b00111;
    localparam logic [4:0] OP_OR  = 5'b01000;
    localparam logic [4:0] OP_NOT = 5'b01001;
    localparam logic [4:0] OP_XOR = 5'b01010;
    localparam logic [4:0] OP_ASL = 5'b10000;
    localparam logic [4:0] OP_ASR = 5'b10001;
    localparam logic [4:0] OP_LSL = 5'b10010;
    localparam logic [4:0] OP_LSR = 5'b10011;
    localparam logic [4:0] OP_ROL = 5'b10100;
    localparam logic [4:0] OP_ROR = 5'b10101;
    localparam logic [4:0] OP_CMP = 5'b11001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [W2-1:0]      work_q, work_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               div0_q, div0_d;
    logic [W2-1:0]      res_q, res_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               ac_q, ac_d;
    logic               parity_q, parity_d;
    logic               err_q, err_d;
    logic               ov_q, ov_d;
    logic               rdy_q, rdy_d;

    // Single-cycle ALU results
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_ac;
    logic               alu_unsup;
    logic               alu_is_cmp;
    logic               alu_is_iter;
    logic [WIDTH:0]     arith;
    logic [4:0]         nib;
    logic [WIDTH:0]     sh_w;
    logic [SHAMT_W:0]   inv_amt;

    // Iteration step results
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_rem;
    logic [WIDTH:0]     div_trial;
    logic [W2-1:0]      step;

    // Complementary rotate distance; amount 0 gives WIDTH, which shifts to 0
    assign inv_amt = (SHAMT_W + 1)'(WIDTH) - {1'b0, s_r_amount};

    // Combinational ALU for the single-cycle opcodes
    always_comb begin : alu
        alu_res     = '0;
        alu_c       = 1'b0;
        alu_ac      = 1'b0;
        alu_unsup   = 1'b0;
        alu_is_cmp  = 1'b0;
        alu_is_iter = 1'b0;
        arith       = '0;
        nib         = '0;
        sh_w        = '0;
        case (opcode)
            OP_MOV: alu_res = op_a;
            OP_ADD: begin
                arith   = {1'b0, op_a} + {1'b0, op_b};
                nib     = {1'b0, op_a[3:0]} + {1'b0, op_b[3:0]};
                alu_res = arith[WIDTH-1:0];
                alu_c   = arith[WIDTH];
                alu_ac  = nib[4];
            end
            OP_SUB: begin
                arith   = {1'b0, op_a} - {1'b0, op_b};
                nib     = {1'b0, op_a[3:0]} - {1'b0, op_b[3:0]};
                alu_res = arith[WIDTH-1:0];
                alu_c   = arith[WIDTH];
                alu_ac  = nib[4];
            end
            OP_INC: begin
                arith   = {1'b0, op_a} + (WIDTH + 1)'(1);
                nib     = {1'b0, op_a[3:0]} + 5'd1;
                alu_res = arith[WIDTH-1:0];
                alu_c   = arith[WIDTH];
                alu_ac  = nib[4];
            end
            OP_DEC: begin
                arith   = {1'b0, op_a} - (WIDTH + 1)'(1);
                nib     = {1'b0, op_a[3:0]} - 5'd1;
                alu_res = arith[WIDTH-1:0];
                alu_c   = arith[WIDTH];
                alu_ac  = nib[4];
            end
            OP_MUL, OP_DIV: alu_is_iter = 1'b1;
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_NOT: alu_res = ~op_a;
            OP_XOR: alu_res = op_a ^ op_b;
            // Extra MSB catches the last bit shifted out of the top
            OP_ASL, OP_LSL: begin
                sh_w    = {1'b0, op_a} << s_r_amount;
                alu_res = sh_w[WIDTH-1:0];
                alu_c   = sh_w[WIDTH];
            end
            // Extra LSB catches the last bit shifted out of the bottom
            OP_ASR: begin
                sh_w    = $signed({op_a, 1'b0}) >>> s_r_amount;
                alu_res = sh_w[WIDTH:1];
                alu_c   = sh_w[0];
            end
            OP_LSR: begin
                sh_w    = {op_a, 1'b0} >> s_r_amount;
                alu_res = sh_w[WIDTH:1];
                alu_c   = sh_w[0];
            end
            OP_ROL: begin
                alu_res = (op_a << s_r_amount) | (op_a >> inv_amt);
                alu_c   = (s_r_amount != '0) & alu_res[0];
            end
            OP_ROR: begin
                alu_res = (op_a >> s_r_amount) | (op_a << inv_amt);
                alu_c   = (s_r_amount != '0) & alu_res[WIDTH-1];
            end
            OP_CMP: begin
                alu_is_cmp = 1'b1;
                alu_res    = {{(WIDTH - 1){1'b0}}, (op_a >= op_b)};
                alu_c      = (op_a < op_b);
            end
            default: alu_unsup = 1'b1;
        endcase
    end

    // One mul/div iteration on {hi, lo} held in work_q
    always_comb begin : iter_step
        mul_sum   = {1'b0, work_q[W2-1:WIDTH]}
                  + (work_q[0] ? {1'b0, opb_q} : (WIDTH + 1)'(0));
        div_rem   = {work_q[W2-1:WIDTH], work_q[WIDTH-1]};
        div_trial = div_rem - {1'b0, opb_q};
        if (is_div_q) begin
            if (!div_trial[WIDTH]) begin
                step = {div_trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
            end else begin
                step = {div_rem[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step = {mul_sum, work_q[WIDTH-1:1]};
        end
    end

    // Next-state and output logic
    always_comb begin : next_state
        state_d  = state_q;
        work_d   = work_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        div0_d   = div0_q;
        res_d    = res_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ac_d     = ac_q;
        parity_d = parity_q;
        err_d    = err_q;
        ov_d     = ov_q;
        rdy_d    = rdy_q;
        case (state_q)
            S_IDLE: begin
                // Flush wins over in_valid: nothing is accepted
                if (in_valid && !flush) begin
                    rdy_d = 1'b0;
                    if (alu_is_iter) begin
                        state_d  = S_BUSY;
                        work_d   = {{WIDTH{1'b0}}, op_a};
                        opb_d    = op_b;
                        cnt_d    = '0;
                        is_div_d = (opcode == OP_DIV);
                        div0_d   = (opcode == OP_DIV) && (op_b == '0);
                    end else begin
                        state_d = S_DONE;
                        ov_d    = 1'b1;
                        err_d   = alu_unsup;
                        if (alu_unsup) begin
                            res_d = '0;
                        end else begin
                            res_d    = {{WIDTH{1'b0}}, alu_res};
                            zero_d   = alu_is_cmp ? (op_a == op_b) : (alu_res == '0);
                            carry_d  = alu_c;
                            ac_d     = alu_ac;
                            parity_d = ^alu_res;
                        end
                    end
                end
            end
            S_BUSY: begin
                if (flush) begin
                    state_d = S_IDLE;
                    rdy_d   = 1'b1;
                end else if (cnt_q == CNT_W'(WIDTH)) begin
                    // All iterations done: publish product or {rem, quot}
                    state_d  = S_DONE;
                    ov_d     = 1'b1;
                    res_d    = work_q;
                    zero_d   = (work_q == '0);
                    carry_d  = 1'b0;
                    ac_d     = 1'b0;
                    parity_d = ^work_q;
                    err_d    = div0_q;
                end else begin
                    work_d = step;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                // Flush alongside out_ready still just drops the result
                if (flush || out_ready) begin
                    state_d = S_IDLE;
                    ov_d    = 1'b0;
                    rdy_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ov_d    = 1'b0;
                rdy_d   = 1'b1;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            work_q   <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ac_q     <= 1'b0;
            parity_q <= 1'b0;
            err_q    <= 1'b0;
            ov_q     <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            div0_q   <= div0_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ac_q     <= ac_d;
            parity_q <= parity_d;
            err_q    <= err_d;
            ov_q     <= ov_d;
            rdy_q    <= rdy_d;
        end
    end

    assign in_ready    = rdy_q;
    assign out_valid   = ov_q;
    assign result      = res_q;
    assign zero_flag   = zero_q;
    assign carry_flag  = carry_q;
    assign ac_flag     = ac_q;
    assign parity_flag = parity_q;
    assign err         = err_q;

endmodule

// File: tb/tb_exec_unit_param.sv
// Randomized self-checking bench for exec_unit_param (WIDTH=8) against an
// arithmetic reference model.
module tb_exec_unit_param;

    localparam int unsigned W = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  opcode;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [2:0]  s_r_amount;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        zero_flag, carry_flag, ac_flag, parity_flag, err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: expected result/flags of the latest op
    logic [15:0] m_res;
    logic        m_z, m_c, m_ac, m_p, m_err;
    int          m_lat;

    exec_unit_param #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .op_a(op_a), .op_b(op_b), .s_r_amount(s_r_amount),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero_flag(zero_flag), .carry_flag(carry_flag),
        .ac_flag(ac_flag), .parity_flag(parity_flag), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: plain integer arithmetic, bit-by-bit shifts
    task automatic model_op(input logic [4:0] opc, input int a, input int b, input int amt);
        int  v, res, c, ac, e;
        bit  sup;
        logic [15:0] rv;
        v = a; res = 0; c = 0; ac = 0; e = 0; sup = 1'b1; m_lat = 1;
        case (opc)
            5'd0:  res = a;
            5'd1:  begin res = (a + b) & 255; c = int'((a + b) > 255); ac = int'(((a & 15) + (b & 15)) > 15); end
            5'd2:  begin res = (a - b) & 255; c = int'(a < b); ac = int'((a & 15) < (b & 15)); end
            5'd3:  begin res = a * b; m_lat = W + 1; end
            5'd4:  begin
                m_lat = W + 1;
                if (b == 0) begin res = (a << 8) | 255; e = 1; end
                else res = ((a % b) << 8) | (a / b);
            end
            5'd5:  begin res = (a + 1) & 255; c = int'(a == 255); ac = int'((a & 15) == 15); end
            5'd6:  begin res = (a - 1) & 255; c = int'(a == 0); ac = int'((a & 15) == 0); end
            5'd7:  res = a & b;
            5'd8:  res = a | b;
            5'd9:  res = (~a) & 255;
            5'd10: res = a ^ b;
            5'd16, 5'd18: begin
                for (int i = 0; i < amt; i++) begin c = (v >> 7) & 1; v = (v << 1) & 255; end
                res = v;
            end
            5'd17: begin
                for (int i = 0; i < amt; i++) begin c = v & 1; v = (v >> 1) | (v & 128); end
                res = v;
            end
            5'd19: begin
                for (int i = 0; i < amt; i++) begin c = v & 1; v = v >> 1; end
                res = v;
            end
            5'd20: begin
                for (int i = 0; i < amt; i++) v = ((v << 1) | (v >> 7)) & 255;
                res = v; c = (amt > 0) ? (v & 1) : 0;
            end
            5'd21: begin
                for (int i = 0; i < amt; i++) v = (v >> 1) | ((v & 1) << 7);
                res = v; c = (amt > 0) ? ((v >> 7) & 1) : 0;
            end
            5'd25: begin res = int'(a >= b); c = int'(a < b); end
            default: sup = 1'b0;
        endcase
        if (sup) begin
            rv    = 16'(res);
            m_res = rv;
            m_z   = (opc == 5'd25) ? (a == b) : (rv == 16'h0);
            m_c   = c[0];
            m_ac  = ac[0];
            m_p   = ^rv;
            m_err = e[0];
        end else begin
            m_res = 16'h0;
            m_err = 1'b1;
        end
    endtask

    // Present one op, accept it on the next edge, then scramble the inputs
    task automatic start_op(input logic [4:0] opc, input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] amt);
        @(negedge clk);
        check_eq("in_ready_before_accept", in_ready, 1);
        opcode = opc; op_a = a; op_b = b; s_r_amount = amt; in_valid = 1'b1;
        model_op(opc, int'(a), int'(b), int'(amt));
        @(posedge clk); #1;
        in_valid = 1'b0;
        opcode = 5'($urandom); op_a = 8'($urandom); op_b = 8'($urandom); s_r_amount = 3'($urandom);
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_result"}, result, m_res);
        check_eq({tag, "_zero"}, zero_flag, m_z);
        check_eq({tag, "_carry"}, carry_flag, m_c);
        check_eq({tag, "_ac"}, ac_flag, m_ac);
        check_eq({tag, "_parity"}, parity_flag, m_p);
        check_eq({tag, "_err"}, err, m_err);
    endtask

    // Wait (bounded) for out_valid and check latency, result and flags
    task automatic wait_done(input string tag);
        int lat = 0;
        int rdy_hi = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!out_valid && in_ready) rdy_hi++;
        end while (!out_valid && lat < 40);
        check_eq({tag, "_latency"}, lat, m_lat);
        check_eq({tag, "_ready_low_busy"}, rdy_hi, 0);
        check_outputs(tag);
    endtask

    // Hold the result for some cycles, then complete the handshake
    task automatic release_op(input string tag, input int hold);
        int bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== m_res ||
                zero_flag !== m_z || carry_flag !== m_c || parity_flag !== m_p) bad++;
        end
        if (hold > 0) check_eq({tag, "_hold_stable"}, bad, 0);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        check_eq({tag, "_valid_drop"}, out_valid, 0);
        check_eq({tag, "_ready_back"}, in_ready, 1);
    endtask

    task automatic do_op(input string tag, input logic [4:0] opc, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] amt, input int hold);
        start_op(opc, a, b, amt);
        wait_done(tag);
        release_op(tag, hold);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic sz, sc, sac, sp, serr;
        int   seen;
        reset = 1'b0; in_valid = 1'b0; opcode = '0; op_a = '0; op_b = '0;
        s_r_amount = '0; flush = 1'b0; out_ready = 1'b0;
        m_z = 0; m_c = 0; m_ac = 0; m_p = 0; m_err = 0; m_res = 0;

        #12;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_flags", {zero_flag, carry_flag, ac_flag, parity_flag}, 0);
        check_eq("rst_err", err, 0);
        @(negedge clk); reset = 1'b1;

        // Directed cases with constant expectations
        start_op(5'd1, 8'hF8, 8'h0A, 3'd0); wait_done("add");
        check_eq("add_k", {result, carry_flag, ac_flag, zero_flag, parity_flag}, {16'h0002, 4'b1101});
        release_op("add", 0);
        start_op(5'd3, 8'h0F, 8'h11, 3'd0); wait_done("mul");
        check_eq("mul_k", {result, parity_flag, zero_flag}, {16'h00FF, 2'b00});
        release_op("mul", 0);
        start_op(5'd4, 8'h64, 8'h07, 3'd0); wait_done("div");
        check_eq("div_k", {result, err}, {16'h020E, 1'b0});
        release_op("div", 1);
        start_op(5'd4, 8'h2A, 8'h00, 3'd0); wait_done("div0");
        check_eq("div0_k", {result, err}, {16'h2AFF, 1'b1});
        release_op("div0", 0);
        start_op(5'd17, 8'h81, 8'h00, 3'd1); wait_done("asr");
        check_eq("asr_k", {result, carry_flag}, {16'h00C0, 1'b1});
        release_op("asr", 0);
        start_op(5'd21, 8'h01, 8'h00, 3'd1); wait_done("ror");
        check_eq("ror_k", {result, carry_flag}, {16'h0080, 1'b1});
        release_op("ror", 0);
        start_op(5'd18, 8'h81, 8'h00, 3'd0); wait_done("lsl0");
        check_eq("lsl0_k", {result, carry_flag}, {16'h0081, 1'b0});
        release_op("lsl0", 0);
        start_op(5'd25, 8'h05, 8'h05, 3'd0); wait_done("cmp");
        check_eq("cmp_k", {result, zero_flag, carry_flag}, {16'h0001, 2'b10});
        release_op("cmp", 0);
        do_op("unsup", 5'd31, 8'h12, 8'h34, 3'd0, 0);

        // Backpressure with a second request waiting
        start_op(5'd1, 8'h12, 8'h34, 3'd0); wait_done("bp");
        @(negedge clk);
        opcode = 5'd10; op_a = 8'h0F; op_b = 8'hF0; in_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== m_res || carry_flag !== m_c) seen++;
        end
        check_eq("bp_hold_stable", seen, 0);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        check_eq("bp_valid_drop", out_valid, 0);
        check_eq("bp_ready_back", in_ready, 1);
        model_op(5'd10, 8'h0F, 8'hF0, 0);
        @(posedge clk); #1; in_valid = 1'b0;
        check_eq("bp_second_valid", out_valid, 1);
        check_outputs("bp_second");
        release_op("bp_second", 0);

        // Flush in IDLE blocks the accept
        @(negedge clk); opcode = 5'd1; op_a = 8'h01; op_b = 8'h01; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        check_eq("flush_idle_ready", in_ready, 1);
        @(negedge clk); in_valid = 1'b0; flush = 1'b0;
        check_eq("flush_idle_no_valid", out_valid, 0);

        // Flush during cycle 3 of a div keeps the prior flags
        do_op("pre_flush", 5'd2, 8'h10, 8'h20, 3'd0, 0);
        sz = m_z; sc = m_c; sac = m_ac; sp = m_p; serr = m_err;
        start_op(5'd4, 8'h64, 8'h07, 3'd0);
        @(posedge clk); @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check_eq("flush_busy_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (out_valid) seen++; end
        check_eq("flush_busy_no_valid", seen, 0);
        check_eq("flush_busy_flags", {zero_flag, carry_flag, ac_flag, parity_flag, err},
                 {sz, sc, sac, sp, serr});
        m_z = sz; m_c = sc; m_ac = sac; m_p = sp; m_err = serr;

        // Flush together with out_ready in DONE
        start_op(5'd6, 8'h00, 8'h00, 3'd0); wait_done("flush_done");
        @(negedge clk); flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1; flush = 1'b0; out_ready = 1'b0;
        check_eq("flush_done_valid", out_valid, 0);
        check_eq("flush_done_ready", in_ready, 1);
        check_eq("flush_done_carry", carry_flag, m_c);

        // Asynchronous reset during cycle 4 of a mul
        do_op("pre_rst", 5'd1, 8'hFF, 8'h01, 3'd0, 0);
        start_op(5'd3, 8'hC3, 8'h5A, 3'd0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_valid", out_valid, 0);
        check_eq("arst_result", result, 0);
        check_eq("arst_flags", {zero_flag, carry_flag, ac_flag, parity_flag, err}, 0);
        m_z = 0; m_c = 0; m_ac = 0; m_p = 0; m_err = 0; m_res = 0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check_eq("arst_ready", in_ready, 1);
        check_eq("arst_no_valid", out_valid, 0);

        // Randomized operations
        for (int n = 0; n < 80; n++) begin
            logic [4:0] ro;
            logic [7:0] ra, rb;
            ro = 5'($urandom_range(0, 31));
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            do_op($sformatf("rnd%0d_op%0d", n, ro), ro, ra, rb, 3'($urandom_range(0, 7)),
                  int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
